// File: rtl/imagem_pixel_streamer.sv
// Image RAM read stage: fetches a run of 32-bit words and
// streams them out as 8-bit pixels on a valid/ready port.
module imagem_pixel_streamer #(
    parameter int ADDR_W     = 18,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_clken,
    input  logic [31:0]       mem_readdata,
    output logic [7:0]        pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_last
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int CNT_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  issued_q;
    logic [CNT_W-1:0]  popped_q;
    logic [OCC_W-1:0]  occ_q;
    logic              rd_pend_q;

    logic [31:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [OCC_W-1:0]  fifo_cnt;

    logic [23:0]       sh_q;
    logic [1:0]        idx_q;
    logic              last_word_q;

    logic              accept;
    logic              issue;
    logic              done_d;
    logic              unp_take;
    logic              pop;
    logic              fifo_wr;
    logic              fifo_rd;
    logic [31:0]       load_word;
    logic [OCC_W-1:0]  occ_eff;

    // RAM clock runs whenever the block is out of reset
    assign mem_clken = reset_n;

    // Next state, issue credit, FIFO steering and completion
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        issue     = 1'b0;
        done_d    = 1'b0;
        unp_take  = !pix_valid || (pix_ready && idx_q == 2'd3);
        fifo_rd   = unp_take && (fifo_cnt != '0);
        pop       = unp_take && ((fifo_cnt != '0) || rd_pend_q);
        fifo_wr   = rd_pend_q && !(unp_take && fifo_cnt == '0);
        load_word = (fifo_cnt != '0) ? fifo_mem[rd_ptr] : mem_readdata;
        occ_eff   = occ_q - OCC_W'(pop);
        unique case (state_q)
            S_IDLE: begin
                if (start && !done) begin
                    accept  = 1'b1;
                    state_d = (word_count == '0) ? S_FLUSH : S_RUN;
                end
            end
            S_RUN: begin
                if (issued_q == count_q) begin
                    state_d = S_FLUSH;
                end else if (occ_eff < OCC_W'(FIFO_DEPTH)) begin
                    issue = 1'b1;
                end
            end
            S_FLUSH: begin
                if (fifo_cnt == '0 && !rd_pend_q &&
                    (!pix_valid || (pix_ready && idx_q == 2'd3))) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state, run parameters and status flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            count_q <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= done_d;
            if (accept) begin
                base_q  <= base_addr;
                count_q <= word_count;
                busy    <= 1'b1;
            end else if (done_d) begin
                busy <= 1'b0;
            end
        end
    end

    // Read request port; occupancy counts FIFO words plus in-flight reads
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_chipselect <= 1'b0;
            mem_address    <= '0;
            issued_q       <= '0;
            occ_q          <= '0;
            rd_pend_q      <= 1'b0;
        end else begin
            rd_pend_q <= mem_chipselect;
            if (accept) begin
                mem_chipselect <= (word_count != '0);
                mem_address    <= base_addr;
                issued_q       <= CNT_W'(word_count != '0);
                occ_q          <= OCC_W'(word_count != '0);
            end else begin
                mem_chipselect <= issue;
                if (issue) begin
                    mem_address <= base_q + issued_q[ADDR_W-1:0];
                end
                issued_q <= issued_q + CNT_W'(issue);
                occ_q    <= occ_eff + OCC_W'(issue);
            end
        end
    end

    // Word FIFO; bypassed when empty and the unpacker is free
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (fifo_wr) begin
                fifo_mem[wr_ptr] <= mem_readdata;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (fifo_rd) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_cnt <= fifo_cnt + OCC_W'(fifo_wr) - OCC_W'(fifo_rd);
        end
    end

    // Unpacker: word to four pixels, low byte first
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            popped_q    <= '0;
            pix_valid   <= 1'b0;
            pix_data    <= '0;
            pix_last    <= 1'b0;
            sh_q        <= '0;
            idx_q       <= '0;
            last_word_q <= 1'b0;
        end else begin
            if (accept) begin
                popped_q <= '0;
            end else if (pop) begin
                popped_q <= popped_q + CNT_W'(1);
            end
            if (pop) begin
                pix_valid   <= 1'b1;
                pix_data    <= load_word[7:0];
                sh_q        <= load_word[31:8];
                idx_q       <= 2'd0;
                pix_last    <= 1'b0;
                last_word_q <= (popped_q + CNT_W'(1) == count_q);
            end else if (pix_valid && pix_ready) begin
                if (idx_q == 2'd3) begin
                    pix_valid <= 1'b0;
                    pix_last  <= 1'b0;
                end else begin
                    pix_data <= sh_q[7:0];
                    sh_q     <= {8'h00, sh_q[23:8]};
                    idx_q    <= idx_q + 2'd1;
                    pix_last <= last_word_q && (idx_q == 2'd2);
                end
            end
        end
    end

    // Credit accounting must make a push into a full FIFO impossible
    a_no_overflow : assert property (
        @(posedge clk) disable iff (!reset_n)
        !(fifo_wr && !fifo_rd && fifo_cnt == OCC_W'(FIFO_DEPTH))
    );

endmodule

// File: tb/tb_imagem_pixel_streamer.sv
// Self-checking bench for imagem_pixel_streamer: RAM model,
// randomized backpressure and a run-level reference of the stream.
module tb_imagem_pixel_streamer;

    localparam int AW    = 18;
    localparam int DEPTH = 4;
    localparam int MASK  = (1 << AW) - 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   word_count;
    logic          busy;
    logic          done;
    logic [AW-1:0] mem_address;
    logic          mem_chipselect;
    logic          mem_clken;
    logic [31:0]   mem_readdata;
    logic [7:0]    pix_data;
    logic          pix_valid;
    logic          pix_ready;
    logic          pix_last;

    logic [31:0] ram [0:(1<<AW)-1];

    int n_checks = 0;
    int n_err    = 0;
    int cyc;

    logic [AW-1:0] rd_q[$];
    int            rd_cyc[$];
    logic [7:0]    px_q[$];
    logic          pl_q[$];
    int            px_cyc[$];
    int            done_cyc[$];
    logic          busy_c1;
    logic          busy_at_done;
    logic          prev_v;
    logic          prev_r;
    logic [7:0]    prev_d;
    logic          prev_l;

    imagem_pixel_streamer #(.ADDR_W(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .base_addr      (base_addr),
        .word_count     (word_count),
        .busy           (busy),
        .done           (done),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata),
        .pix_data       (pix_data),
        .pix_valid      (pix_valid),
        .pix_ready      (pix_ready),
        .pix_last       (pix_last)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: registered address, data the cycle after a request
    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            mem_readdata <= ram[mem_address];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit rdy_for(input int mode, input int c);
        if (mode == 0) return 1'b1;
        if (mode == 1) return ($urandom_range(0, 99) < 30);
        if (c < 30) return 1'b0;
        return ($urandom_range(0, 99) < 30);
    endfunction

    task automatic clear();
        rd_q.delete();
        rd_cyc.delete();
        px_q.delete();
        pl_q.delete();
        px_cyc.delete();
        done_cyc.delete();
        busy_c1      = 1'b0;
        busy_at_done = 1'b1;
        prev_v       = 1'b0;
        prev_r       = 1'b0;
        cyc          = -1;
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, ":busy"}, busy, 0);
        chk({nm, ":done"}, done, 0);
        chk({nm, ":cs"}, mem_chipselect, 0);
        chk({nm, ":addr"}, mem_address, 0);
        chk({nm, ":clken"}, mem_clken, 0);
        chk({nm, ":valid"}, pix_valid, 0);
        chk({nm, ":data"}, pix_data, 0);
        chk({nm, ":last"}, pix_last, 0);
    endtask

    // One clock: observe cycle outputs at the falling edge, then drive
    task automatic tick(input bit st, input bit rdy, input bit poke_done);
        @(negedge clk);
        cyc++;
        if (prev_v && !prev_r) begin
            chk("hold_valid", pix_valid, 1);
            chk("hold_data", pix_data, prev_d);
            chk("hold_last", pix_last, prev_l);
        end
        if (mem_chipselect) begin
            rd_q.push_back(mem_address);
            rd_cyc.push_back(cyc);
        end
        chk("credit", (rd_q.size() - px_q.size() / 4) <= DEPTH + 1, 1);
        if (pix_valid && rdy) begin
            px_q.push_back(pix_data);
            pl_q.push_back(pix_last);
            px_cyc.push_back(cyc);
        end
        if (done) begin
            done_cyc.push_back(cyc);
            busy_at_done = busy;
        end
        if (cyc == 1) busy_c1 = busy;
        start     = st || (poke_done && done);
        pix_ready = rdy;
        prev_v    = pix_valid;
        prev_r    = rdy;
        prev_d    = pix_data;
        prev_l    = pix_last;
    endtask

    // Full run against the reference stream built from the RAM contents
    task automatic run(input logic [AW-1:0] b, input int n, input int mode,
                       input bit poke, input string nm);
        int np;
        logic [31:0] w;
        clear();
        base_addr  = b;
        word_count = n[AW:0];
        tick(1'b1, rdy_for(mode, 0), 1'b0);
        while (done_cyc.size() == 0 && cyc < 3000) begin
            tick(poke && (cyc % 7 == 2), rdy_for(mode, cyc + 1), poke);
        end
        repeat (4) tick(1'b0, 1'b1, 1'b0);
        start = 1'b0;
        chk({nm, ":done_count"}, done_cyc.size(), 1);
        chk({nm, ":read_count"}, rd_q.size(), n);
        for (int i = 0; i < rd_q.size() && i < n; i++) begin
            chk({nm, ":read_addr"}, rd_q[i], (b + i) & MASK);
        end
        np = 4 * n;
        chk({nm, ":pix_count"}, px_q.size(), np);
        for (int k = 0; k < px_q.size() && k < np; k++) begin
            w = ram[(b + k / 4) & MASK];
            chk({nm, ":pix_data"}, px_q[k], (w >> (8 * (k % 4))) & 8'hFF);
            chk({nm, ":pix_last"}, pl_q[k], k == np - 1);
        end
        if (n == 0 && done_cyc.size() > 0) begin
            chk({nm, ":zero_done_cyc"}, done_cyc[0], 2);
        end
        if (n > 0 && done_cyc.size() > 0 && px_q.size() > 0) begin
            chk({nm, ":busy_c1"}, busy_c1, 1);
            chk({nm, ":busy_at_done"}, busy_at_done, 0);
            chk({nm, ":done_after_last"}, done_cyc[0], px_cyc[$] + 1);
        end
        if (n > 0 && rd_cyc.size() > 0) begin
            chk({nm, ":first_read_cyc"}, rd_cyc[0], 1);
        end
        if (mode == 0 && n > 0 && done_cyc.size() > 0) begin
            for (int k = 0; k < px_cyc.size(); k++) begin
                chk({nm, ":pix_cyc"}, px_cyc[k], 3 + k);
            end
            chk({nm, ":done_cyc"}, done_cyc[0], 3 + 4 * n);
        end
        if (mode == 2 && rd_cyc.size() > 5 && px_cyc.size() > 3) begin
            chk({nm, ":stall_reads"}, rd_cyc[4], 5);
            chk({nm, ":resume_read"}, rd_cyc[5], px_cyc[3] + 1);
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        start      = 1'b0;
        pix_ready  = 1'b0;
        base_addr  = '0;
        word_count = '0;
        for (int i = 0; i < (1 << AW); i++) ram[i] = $urandom;
        ram[18'h10] = 32'h44332211;
        ram[18'h11] = 32'h88776655;

        repeat (3) @(negedge clk);
        #1 chk_reset_vals("reset");

        reset_n = 1'b1;
        clear();
        repeat (100) tick(1'b0, 1'b0, 1'b0);
        chk("idle_no_cs", rd_q.size(), 0);
        chk("idle_clken", mem_clken, 1);

        run(18'h00010, 2, 0, 1'b0, "basic");
        chk("basic_first", px_q.size() > 0 ? px_q[0] : 8'h00, 8'h11);
        chk("basic_final", px_q.size() > 7 ? px_q[7] : 8'h00, 8'h88);
        run(18'h3FFFF, 3, 0, 1'b0, "wrap");
        run(18'h00123, 0, 0, 1'b0, "zero");
        run(AW'($urandom), 16, 2, 1'b0, "bp");
        run(AW'($urandom), 7, 1, 1'b0, "rand");
        run(AW'($urandom), 8, 0, 1'b1, "poke");

        clear();
        base_addr  = AW'($urandom);
        word_count = 19'd10;
        tick(1'b1, 1'b1, 1'b0);
        while (px_q.size() < 16 && cyc < 200) tick(1'b0, 1'b1, 1'b0);
        chk("mid_reached", px_q.size(), 16);
        #2 reset_n = 1'b0;
        #1 chk_reset_vals("mid_rst");
        repeat (3) tick(1'b0, 1'b1, 1'b0);
        chk("mid_no_done", done_cyc.size(), 0);
        chk("mid_no_valid", pix_valid, 0);
        reset_n = 1'b1;
        repeat (2) tick(1'b0, 1'b1, 1'b0);
        chk("mid_idle_busy", busy, 0);

        run(AW'($urandom), 5, 1, 1'b0, "post_rst");
        run(AW'($urandom), 4, 0, 1'b0, "post_rst2");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/imagem_pixel_streamer.md
# imagem_pixel_streamer

- Read-side stage sitting directly on the image on-chip RAM port: 32-bit words, 18-bit word address, registered address, unregistered output.
- Started by a command; reads a programmed run of words from the RAM and unpacks each word into four 8-bit pixels.
- Emits pixels on a valid/ready stream to the downstream display/processing pipeline.
- An internal word FIFO with read-credit accounting absorbs the RAM's 1-cycle read latency and downstream backpressure without losing data.

## Interface

Parameters:
- ADDR_W, 18, RAM word-address width
- FIFO_DEPTH, 4, word FIFO depth (power of two, ≥2)

Ports:
- clk  in  1  system clock; single clock domain
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  1-cycle command pulse; sampled only in IDLE
- base_addr  in  ADDR_W  first word address, latched on accepted start
- word_count  in  ADDR_W+1  words to read, 0..2^ADDR_W, latched on accepted start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  1-cycle completion pulse
- mem_address  out  ADDR_W  RAM word address
- mem_chipselect  out  1  read request; one word per asserted cycle
- mem_clken  out  1  RAM clock enable; 0 in reset, 1 otherwise
- mem_readdata  in  32  RAM read data, valid the cycle after the request
- pix_data  out  8  pixel byte
- pix_valid  out  1  pixel available
- pix_ready  in  1  downstream accepts; transfer when valid & ready
- pix_last  out  1  marks the final pixel of the run

## Operation

- States: IDLE, RUN, FLUSH.
- IDLE:
  - start latches base_addr/word_count and clears counters.
  - word_count==0: go to FLUSH with nothing queued, so done pulses next cycle and no RAM access occurs.
  - Otherwise go to RUN.
- RUN:
  - Issue a read (mem_chipselect=1, mem_address=base+issued) when issued<word_count and fifo_count+inflight<FIFO_DEPTH.
  - inflight is 0 or 1. Each read is written into the FIFO exactly one cycle after its request.
  - When issued==word_count, go to FLUSH.
- FLUSH:
  - Wait until the FIFO, inflight and the unpacker are all empty.
  - Then done=1 for one cycle, busy=0 in the same cycle, and return to IDLE.
- Address arithmetic: base+issued is mod 2^ADDR_W, so 0x3FFFF wraps to 0x00000.
- Unpacker:
  - Pops one word when idle or when its last byte is transferring.
  - Byte order per word: [7:0], [15:8], [23:16], [31:24].
  - pix_data/pix_valid hold stable while pix_ready=0.
- pix_last=1 only on byte [31:24] of the final word.
- start while busy: ignored; no effect on the run in progress.
- start in the same cycle as done: ignored; a new run needs start in IDLE.
- FIFO push and pop in the same cycle are allowed; count stays the same.
- No FIFO overflow is possible by credit rule. Any overflow is a design error for the assertion checker.
- reset_n low at any time, including mid-run: immediate return to IDLE.
  - All counters and the FIFO are cleared.
  - In-flight read data is discarded.
  - No done pulse is generated.

## Timing

- Reset values: busy=0, done=0, mem_chipselect=0, mem_address=0, mem_clken=0, pix_valid=0, pix_data=0, pix_last=0.
- start sampled in cycle 0 → busy=1 and first read issued in cycle 1.
- Word in FIFO at the end of cycle 2; first pix_valid in cycle 3.
- With pix_ready held 1: one pixel per cycle sustained, no bubbles after the first pixel.
  - Reads occur at most 1 per cycle, averaging 1 per 4 cycles at steady state.
- N words with pix_ready=1:
  - Last pixel in cycle 3+4N−1.
  - done in the cycle after the last pixel transfer.
- Backpressure: with pix_ready=0, reads stop once fifo_count+inflight=FIFO_DEPTH. They resume the cycle after a pop frees a slot.
- All outputs are registered except mem_clken, which is combinational from reset_n.

## Test plan

- Reset values: assert reset_n=0 → every output at its listed reset value; release, no start → no mem_chipselect for 100 cycles.
- Basic run: base=0x00010, count=2, RAM[0x10]=0x44332211, RAM[0x11]=0x88776655, pix_ready=1.
  - Pixels 11,22,33,44,55,66,77,88 in cycles 3–10.
  - pix_last only on 88.
  - done in cycle 11, busy falls in cycle 11.
- Wrap and zero count:
  - base=0x3FFFF, count=3 → reads at 0x3FFFF, 0x00000, 0x00001.
  - count=0 → done 2 cycles after start, no chipselect, no pixels.
- Backpressure: count=16, pix_ready random 30% high.
  - All 64 bytes delivered in order, none duplicated.
  - fifo_count+inflight never exceeds 4; data holds stable while stalled.
- Control corner cases: start pulses while busy → ignored (single done, original byte stream). reset_n low mid-run at word 5 of 10 → outputs return to reset values asynchronously, no done pulse. A new run afterwards → correct data.
